// File: rtl/fp_addsub_arbiter_if.sv
// fp_addsub_arbiter_if
//   Groups the two cores' request/response channels and the operand/result
//   bus of the shared single-precision add/sub unit.
//   slave  : arbiter side (receives requests, drives responses and operands)
//   master : core / shared-unit side
//   Signals:
//     reqN_valid/ready/op/a/b   request channel of core N (N = 0, 1)
//     respN_valid/ready/data    response channel of core N
//     fpu_a/fpu_b/fpu_op        registered operands to the shared unit
//     fpu_result                result returned by the shared unit
interface fp_addsub_arbiter_if;
  localparam int unsigned DATA_W = 32;

  logic              req0_valid;
  logic              req0_ready;
  logic              req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic              req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;

  logic              resp0_valid;
  logic              resp0_ready;
  logic [DATA_W-1:0] resp0_data;

  logic              resp1_valid;
  logic              resp1_ready;
  logic [DATA_W-1:0] resp1_data;

  logic [DATA_W-1:0] fpu_a;
  logic [DATA_W-1:0] fpu_b;
  logic              fpu_op;
  logic [DATA_W-1:0] fpu_result;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_data, resp1_valid, resp1_data,
    input  resp0_ready, resp1_ready,
    output fpu_a, fpu_b, fpu_op,
    input  fpu_result
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_data, resp1_valid, resp1_data,
    output resp0_ready, resp1_ready,
    input  fpu_a, fpu_b, fpu_op,
    output fpu_result
  );
endinterface

// File: rtl/fp_addsub_arbiter.sv
// fp_addsub_arbiter
//   Shares one external single-precision add/sub unit between two cores.
//   Round-robin grant in IDLE, operands registered to the unit in EXEC,
//   result returned on the owner's response channel in RESP.
//   Optional performance counters are built when FPARB_PERF_CNT_EN is defined.
//   Ports:
//     clk            clock, rising edge
//     rst            synchronous active-high reset
//     bus            fp_addsub_arbiter_if.slave (request/response/unit bus)
//     busy           high whenever the FSM is not in IDLE
//     perf_grant0    accepted core0 requests   (FPARB_PERF_CNT_EN only)
//     perf_grant1    accepted core1 requests   (FPARB_PERF_CNT_EN only)
//     perf_conflict  IDLE cycles with both requests valid (FPARB_PERF_CNT_EN only)
module fp_addsub_arbiter #(
  parameter int unsigned LATENCY = 0
`ifdef FPARB_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  fp_addsub_arbiter_if.slave bus,
  output logic               busy
`ifdef FPARB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   perf_grant0,
  output logic [CNT_W-1:0]   perf_grant1,
  output logic [CNT_W-1:0]   perf_conflict
`endif
);

  localparam int unsigned WAIT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              grant;
  logic              owner;
  logic              last_grant;
  logic [WAIT_W-1:0] wait_cnt;
  logic              accept;
  logic              lat_done;
  logic              resp_fire;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = EXEC;
      EXEC:    if (lat_done)  state_next = RESP;
      RESP:    if (resp_fire) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Grant, ready and handshake decode
  always_comb begin
    // Tie (or no request) favours the core that did not win last time
    grant = ~last_grant;
    if (bus.req0_valid && !bus.req1_valid) begin
      grant = 1'b0;
    end else if (bus.req1_valid && !bus.req0_valid) begin
      grant = 1'b1;
    end
    bus.req0_ready = (state == IDLE) && !grant;
    bus.req1_ready = (state == IDLE) && grant;
    accept    = (bus.req0_valid && bus.req0_ready) ||
                (bus.req1_valid && bus.req1_ready);
    lat_done  = (state == EXEC) && (wait_cnt == WAIT_W'(LATENCY));
    resp_fire = (state == RESP) &&
                (owner ? (bus.resp1_valid && bus.resp1_ready)
                       : (bus.resp0_valid && bus.resp0_ready));
  end

  // Operand latch, wait counter, result capture and response channels
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.fpu_a       <= '0;
      bus.fpu_b       <= '0;
      bus.fpu_op      <= 1'b0;
      bus.resp0_valid <= 1'b0;
      bus.resp1_valid <= 1'b0;
      bus.resp0_data  <= '0;
      bus.resp1_data  <= '0;
      owner           <= 1'b0;
      last_grant      <= 1'b1;
      wait_cnt        <= '0;
      busy            <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      if (accept) begin
        bus.fpu_op <= grant ? bus.req1_op : bus.req0_op;
        bus.fpu_a  <= grant ? bus.req1_a  : bus.req0_a;
        bus.fpu_b  <= grant ? bus.req1_b  : bus.req0_b;
        owner      <= grant;
        wait_cnt   <= '0;
      end
      if ((state == EXEC) && !lat_done) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      // Result bits are passed through untouched
      if (lat_done) begin
        if (owner) begin
          bus.resp1_data  <= bus.fpu_result;
          bus.resp1_valid <= 1'b1;
        end else begin
          bus.resp0_data  <= bus.fpu_result;
          bus.resp0_valid <= 1'b1;
        end
      end
      if (resp_fire) begin
        bus.resp0_valid <= 1'b0;
        bus.resp1_valid <= 1'b0;
        last_grant      <= owner;
      end
    end
  end

`ifdef FPARB_PERF_CNT_EN
  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant0   <= '0;
      perf_grant1   <= '0;
      perf_conflict <= '0;
    end else begin
      if (accept && !grant && (perf_grant0 != '1)) begin
        perf_grant0 <= perf_grant0 + CNT_W'(1);
      end
      if (accept && grant && (perf_grant1 != '1)) begin
        perf_grant1 <= perf_grant1 + CNT_W'(1);
      end
      if ((state == IDLE) && bus.req0_valid && bus.req1_valid &&
          (perf_conflict != '1)) begin
        perf_conflict <= perf_conflict + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// tb_fp_addsub_arbiter
//   Two arbiter instances: index 0 with LATENCY=0 (combinational unit model),
//   index 1 with LATENCY=3 (3-stage pipelined unit model). A transaction-level
//   model predicts every output each cycle; directed literals pin the model.
module tb_fp_addsub_arbiter;

  typedef struct packed {
    logic        once;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        q_valid [2][2];
  logic        q_op    [2][2];
  logic [31:0] q_a     [2][2];
  logic [31:0] q_b     [2][2];
  logic        q_ready [2][2];
  logic        r_ready [2][2];
  logic        r_valid [2][2];
  logic [31:0] r_data  [2][2];
  logic [31:0] f_a     [2];
  logic [31:0] f_b     [2];
  logic        f_op    [2];
  logic        busy    [2];
`ifdef FPARB_PERF_CNT_EN
  logic [15:0] pg0 [2];
  logic [15:0] pg1 [2];
  logic [15:0] pcf [2];
`endif

  int checks = 0;
  int errors = 0;

  // Stand-in for the shared FP unit: known IEEE vectors, otherwise a bit scramble
  function automatic logic [31:0] fake_fpu(input logic [31:0] a, input logic [31:0] b,
                                           input logic op);
    if (!op && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (op && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
    if (a == 32'h7FC00000 || b == 32'h7FC00000) return 32'h7FC00000;
    if (!op && a == 32'h80000000 && b == 32'h80000000) return 32'h80000000;
    return a ^ {b[15:0], b[31:16]} ^ {31'd0, op};
  endfunction

  function automatic int lat(input int k);
    return k * 3;
  endfunction

  function automatic int pick(input logic v0, input logic v1, input int last);
    if (v0 && v1) return (last == 0) ? 1 : 0;
    return v1 ? 1 : 0;
  endfunction

  fp_addsub_arbiter_if bus [2] ();

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [31:0] pipe [3];
    assign bus[g].req0_valid  = q_valid[g][0];
    assign bus[g].req0_op     = q_op[g][0];
    assign bus[g].req0_a      = q_a[g][0];
    assign bus[g].req0_b      = q_b[g][0];
    assign bus[g].req1_valid  = q_valid[g][1];
    assign bus[g].req1_op     = q_op[g][1];
    assign bus[g].req1_a      = q_a[g][1];
    assign bus[g].req1_b      = q_b[g][1];
    assign bus[g].resp0_ready = r_ready[g][0];
    assign bus[g].resp1_ready = r_ready[g][1];
    assign q_ready[g][0] = bus[g].req0_ready;
    assign q_ready[g][1] = bus[g].req1_ready;
    assign r_valid[g][0] = bus[g].resp0_valid;
    assign r_valid[g][1] = bus[g].resp1_valid;
    assign r_data[g][0]  = bus[g].resp0_data;
    assign r_data[g][1]  = bus[g].resp1_data;
    assign f_a[g]  = bus[g].fpu_a;
    assign f_b[g]  = bus[g].fpu_b;
    assign f_op[g] = bus[g].fpu_op;

    always @(posedge clk) begin
      pipe[0] <= fake_fpu(bus[g].fpu_a, bus[g].fpu_b, bus[g].fpu_op);
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign bus[g].fpu_result = (g == 0) ? fake_fpu(bus[g].fpu_a, bus[g].fpu_b, bus[g].fpu_op)
                                        : pipe[2];

    fp_addsub_arbiter #(.LATENCY(g * 3)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus[g]),
      .busy          (busy[g])
`ifdef FPARB_PERF_CNT_EN
      ,
      .perf_grant0   (pg0[g]),
      .perf_grant1   (pg1[g]),
      .perf_conflict (pcf[g])
`endif
    );
  end

  task automatic chk(input string nm, input int k, input int n,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d core=%0d got=%08h want=%08h t=%0t", nm, k, n, act, exp, $time);
    end
  endtask

  // ---------------- request driver: holds each queued request until accepted
  req_t rq [4][$];
  logic cur_once [4];
  logic hs [2][2];
  logic rec_en = 1'b0;
  int   gq [$];

  task automatic push(input int k, input int n, input logic op, input logic [31:0] a,
                      input logic [31:0] b, input logic once);
    req_t r;
    r.once = once;
    r.op   = op;
    r.a    = a;
    r.b    = b;
    rq[k * 2 + n].push_back(r);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 2; n++) begin
        hs[k][n] = q_valid[k][n] && q_ready[k][n] && !rst;
        if (rec_en && k == 0 && hs[k][n]) gq.push_back(n);
      end
    end
  end

  initial begin
    int k;
    int n;
    for (int i = 0; i < 4; i++) begin
      k = i / 2;
      n = i % 2;
      q_valid[k][n] = 1'b0;
      q_op[k][n]    = 1'b0;
      q_a[k][n]     = '0;
      q_b[k][n]     = '0;
      cur_once[i]   = 1'b0;
      hs[k][n]      = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        k = i / 2;
        n = i % 2;
        if ((hs[k][n] || (q_valid[k][n] && cur_once[i])) && rq[i].size() > 0)
          void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          q_valid[k][n] = 1'b1;
          q_op[k][n]    = rq[i][0].op;
          q_a[k][n]     = rq[i][0].a;
          q_b[k][n]     = rq[i][0].b;
          cur_once[i]   = rq[i][0].once;
        end else begin
          q_valid[k][n] = 1'b0;
          cur_once[i]   = 1'b0;
        end
      end
    end
  end

  // ---------------- transaction-level model
  // age counts clock edges since acceptance; the result is on offer once age > LATENCY
  logic        m_inf  [2];
  int          m_age  [2];
  int          m_own  [2];
  int          m_last [2];
  logic [31:0] m_fa   [2];
  logic [31:0] m_fb   [2];
  logic        m_fop  [2];
  logic [31:0] m_data [2][2];
  int          m_pg   [2][2];
  int          m_pcf  [2];

  initial begin
    int g;
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          m_inf[k] = 1'b0; m_age[k] = 0; m_own[k] = 0; m_last[k] = 1;
          m_fa[k] = '0; m_fb[k] = '0; m_fop[k] = 1'b0;
          m_data[k][0] = '0; m_data[k][1] = '0;
          m_pg[k][0] = 0; m_pg[k][1] = 0; m_pcf[k] = 0;
        end else if (!m_inf[k]) begin
          if (q_valid[k][0] && q_valid[k][1] && m_pcf[k] < 65535) m_pcf[k]++;
          if (q_valid[k][0] || q_valid[k][1]) begin
            g = pick(q_valid[k][0], q_valid[k][1], m_last[k]);
            m_own[k] = g;
            m_fa[k]  = q_a[k][g];
            m_fb[k]  = q_b[k][g];
            m_fop[k] = q_op[k][g];
            m_inf[k] = 1'b1;
            m_age[k] = 0;
            if (m_pg[k][g] < 65535) m_pg[k][g]++;
          end
        end else if (m_age[k] > lat(k)) begin
          if (r_ready[k][m_own[k]]) begin
            m_inf[k]  = 1'b0;
            m_last[k] = m_own[k];
          end
        end else begin
          m_age[k]++;
          if (m_age[k] > lat(k)) m_data[k][m_own[k]] = fake_fpu(m_fa[k], m_fb[k], m_fop[k]);
        end
      end
    end
  end

  // ---------------- per-cycle comparison against the model
  initial begin
    logic exp_rv;
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("busy", k, 0, 32'(busy[k]), 32'(m_inf[k]));
        chk("fpu_a", k, 0, f_a[k], m_fa[k]);
        chk("fpu_b", k, 0, f_b[k], m_fb[k]);
        chk("fpu_op", k, 0, 32'(f_op[k]), 32'(m_fop[k]));
        for (int n = 0; n < 2; n++) begin
          exp_rv = m_inf[k] && (m_age[k] > lat(k)) && (m_own[k] == n);
          chk("resp_valid", k, n, 32'(r_valid[k][n]), 32'(exp_rv));
          chk("resp_data", k, n, r_data[k][n], m_data[k][n]);
          if (m_inf[k])
            chk("req_ready_busy", k, n, 32'(q_ready[k][n]), 32'd0);
          else if (q_valid[k][0] || q_valid[k][1])
            chk("req_ready", k, n, 32'(q_ready[k][n]),
                32'(pick(q_valid[k][0], q_valid[k][1], m_last[k]) == n));
        end
`ifdef FPARB_PERF_CNT_EN
        chk("perf_grant0", k, 0, 32'(pg0[k]), 32'(m_pg[k][0]));
        chk("perf_grant1", k, 1, 32'(pg1[k]), 32'(m_pg[k][1]));
        chk("perf_conflict", k, 0, 32'(pcf[k]), 32'(m_pcf[k]));
`endif
      end
    end
  end

  // Returns at the negedge of the cycle in which the request is accepted
  task automatic wait_accept(input int k, input int n);
    logic seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (q_valid[k][n] && q_ready[k][n]) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL accept_timeout inst=%0d core=%0d got=0 want=1", k, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  // ---------------- directed stimulus
  initial begin
    int exp_order [4];
    exp_order = '{0, 1, 0, 1};
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      r_ready[k][0] = 1'b1;
      r_ready[k][1] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 0, 0, 32'(busy[0]), 32'd0);
    chk("reset_fpu_a", 1, 0, f_a[1], 32'd0);
    chk("reset_resp_valid", 1, 1, 32'(r_valid[1][1]), 32'd0);

    // 1.0 + 2.0 on core0, LATENCY=0
    push(0, 0, 1'b0, 32'h3F800000, 32'h40000000, 1'b0);
    wait_accept(0, 0);
    @(negedge clk);
    chk("t1_valid_early", 0, 0, 32'(r_valid[0][0]), 32'd0);
    @(negedge clk);
    chk("t1_valid", 0, 0, 32'(r_valid[0][0]), 32'd1);
    chk("t1_data", 0, 0, r_data[0][0], 32'h40400000);

    // 3.0 - 1.0 on core1
    push(0, 1, 1'b1, 32'h40400000, 32'h3F800000, 1'b0);
    wait_accept(0, 1);
    repeat (2) @(negedge clk);
    chk("t2_data", 0, 1, r_data[0][1], 32'h40000000);
    chk("t2_other_valid", 0, 0, 32'(r_valid[0][0]), 32'd0);
    repeat (3) @(posedge clk);

    // Both cores contend straight out of reset
    #1 rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push(0, 0, 1'b0, 32'h11110000 + 32'(i), 32'h2222, 1'b0);
      push(0, 1, 1'b1, 32'h33330000 + 32'(i), 32'h4444, 1'b0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    rec_en = 1'b1;
    for (int i = 0; i < 40 && gq.size() < 4; i++) @(negedge clk);
    rec_en = 1'b0;
    chk("t3_grant_count", 0, 0, 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < gq.size()) chk("t3_grant_order", 0, i, 32'(gq[i]), 32'(exp_order[i]));
    repeat (4) @(negedge clk);
`ifdef FPARB_PERF_CNT_EN
    chk("t3_perf_grant0", 0, 0, 32'(pg0[0]), 32'd2);
    chk("t3_perf_grant1", 0, 1, 32'(pg1[0]), 32'd2);
    chk("t3_perf_conflict_ge1", 0, 0, 32'(pcf[0] >= 16'd1), 32'd1);
`endif

    // Back-pressure on core0 blocks core1; core1 also drops one request unserved
    @(posedge clk);
    #1 r_ready[0][0] = 1'b0;
    push(0, 0, 1'b0, 32'h7FC00000, 32'h3F800000, 1'b0);
    push(0, 1, 1'b0, 32'h3F800000, 32'h40000000, 1'b1);
    push(0, 1, 1'b0, 32'h80000000, 32'h80000000, 1'b0);
    wait_accept(0, 0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 0, 0, 32'(r_valid[0][0]), 32'd1);
      chk("t4_hold_data", 0, 0, r_data[0][0], 32'h7FC00000);
      chk("t4_core1_blocked", 0, 1, 32'(q_ready[0][1]), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 r_ready[0][0] = 1'b1;
    wait_accept(0, 1);
    repeat (2) @(negedge clk);
    chk("t4_core1_data", 0, 1, r_data[0][1], 32'h80000000);
    chk("t4_core0_data_kept", 0, 0, r_data[0][0], 32'h7FC00000);

    // LATENCY=3: reset during the second EXEC cycle discards the operation
    push(1, 0, 1'b0, 32'h3F800000, 32'h40000000, 1'b0);
    wait_accept(1, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_busy", 1, 0, 32'(busy[1]), 32'd0);
    chk("t5_fpu_a", 1, 0, f_a[1], 32'd0);
    chk("t5_fpu_b", 1, 0, f_b[1], 32'd0);
    chk("t5_resp_valid", 1, 0, 32'(r_valid[1][0]), 32'd0);
    chk("t5_resp_data", 1, 0, r_data[1][0], 32'd0);
    repeat (8) @(negedge clk);
    chk("t5_no_resp", 1, 0, 32'(r_valid[1][0]), 32'd0);
    push(1, 1, 1'b1, 32'h40400000, 32'h3F800000, 1'b0);
    wait_accept(1, 1);
    repeat (4) @(negedge clk);
    chk("t5_valid_early", 1, 1, 32'(r_valid[1][1]), 32'd0);
    @(negedge clk);
    chk("t5_valid", 1, 1, 32'(r_valid[1][1]), 32'd1);
    chk("t5_data", 1, 1, r_data[1][1], 32'h40000000);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
